// File: rtl/gru_serial_pkg.sv
// Shared state encodings and sizing helpers for the GRU serial front end.
// GRU_SERIAL_PARITY_EN adds one even-parity bit after every serial word.
package gru_serial_pkg;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_SHIFT = 2'd1;
   localparam logic [1:0] RX_FULL  = 2'd2;

   localparam logic [2:0] TX_IDLE  = 3'd0;
   localparam logic [2:0] TX_SETUP = 3'd1;
   localparam logic [2:0] TX_HIGH  = 3'd2;
   localparam logic [2:0] TX_LOW   = 3'd3;
   localparam logic [2:0] TX_END   = 3'd4;

`ifdef GRU_SERIAL_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Counters reach their bound exactly, so one bit above $clog2 is kept.
   function automatic int cnt_width(input int bound);
      return $clog2(bound) + 1;
   endfunction

endpackage

// File: rtl/gru_serial_sync.sv
// Synchroniser chain for one asynchronous serial input with rising-edge detect.
// Level and edge are both taken from the second-to-last stage so data and clock stay aligned.
module gru_serial_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q    = chain[STAGES-2];
   assign rise = chain[STAGES-2] & ~chain[STAGES-1];

endmodule

// File: rtl/gru_serial_io.sv
// Bit-serial front end for the GRU accelerator: independent RX deserialiser and TX serialiser.
// Define GRU_SERIAL_PARITY_EN to append and check an even-parity bit after every word.
module gru_serial_io
   import gru_serial_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int IN_WORDS    = 9,
   parameter int OUT_WORDS   = 1,
   parameter int CLK_DIV     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            serial_data_in,
   input  logic                            serial_clk_in,
   input  logic                            serial_load_en,
   output logic [IN_WORDS*DATA_WIDTH-1:0]  o_seq_flat,
   output logic                            o_seq_valid,
   input  logic                            i_seq_ack,
   input  logic [OUT_WORDS*DATA_WIDTH-1:0] i_result_flat,
   input  logic                            i_result_valid,
   output logic                            o_result_ack,
   output logic                            serial_data_out,
   output logic                            serial_clk_out,
   output logic                            serial_valid,
   output logic                            o_rx_err,
   output logic                            o_tx_busy
);

   localparam int WORD_BITS = DATA_WIDTH + PARITY_BITS;
   localparam int SHIFT_W   = DATA_WIDTH - 1 + PARITY_BITS;
   localparam int TX_BITS   = OUT_WORDS * WORD_BITS;
   localparam int RXB_W     = cnt_width(WORD_BITS);
   localparam int RXW_W     = cnt_width(IN_WORDS);
   localparam int TXB_W     = cnt_width(TX_BITS);
   localparam int DIV_W     = cnt_width(CLK_DIV);

   localparam logic [RXB_W-1:0] LAST_BIT  = RXB_W'(WORD_BITS - 1);
   localparam logic [RXW_W-1:0] LAST_WORD = RXW_W'(IN_WORDS - 1);
   localparam logic [TXB_W-1:0] LAST_TX   = TXB_W'(TX_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

   logic rx_din, rx_clk_rise, load_lvl, load_rise;
   logic sdata_rise_unused, sclk_level_unused;

   gru_serial_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .rstn(rstn), .d(serial_data_in), .q(rx_din), .rise(sdata_rise_unused)
   );
   gru_serial_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk), .rstn(rstn), .d(serial_clk_in), .q(sclk_level_unused), .rise(rx_clk_rise)
   );
   gru_serial_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
      .clk(clk), .rstn(rstn), .d(serial_load_en), .q(load_lvl), .rise(load_rise)
   );

   logic [1:0]                     rx_state;
   logic [RXB_W-1:0]               rx_bit_cnt;
   logic [RXW_W-1:0]               rx_word_cnt;
   logic [SHIFT_W-1:0]             rx_shift;
   logic [IN_WORDS*DATA_WIDTH-1:0] rx_buf;
   logic [IN_WORDS*DATA_WIDTH-1:0] rx_frame;
   logic [DATA_WIDTH-1:0]          word_val;
   logic                           word_done;
   logic                           par_ok;

   // With parity the final bit of a word is the parity bit, otherwise it is the data LSB.
   always_comb begin
      word_done = rx_clk_rise && (rx_bit_cnt == LAST_BIT);
`ifdef GRU_SERIAL_PARITY_EN
      word_val  = rx_shift;
      par_ok    = ((^rx_shift) == rx_din);
`else
      word_val  = {rx_shift, rx_din};
      par_ok    = 1'b1;
`endif
      rx_frame  = rx_buf;
      rx_frame[(IN_WORDS-1)*DATA_WIDTH +: DATA_WIDTH] = word_val;
   end

   // Words land in a staging buffer; o_seq_flat only changes when a whole frame is good.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_state    <= RX_IDLE;
         rx_bit_cnt  <= '0;
         rx_word_cnt <= '0;
         rx_shift    <= '0;
         rx_buf      <= '0;
         o_seq_flat  <= '0;
         o_seq_valid <= 1'b0;
         o_rx_err    <= 1'b0;
      end else begin
         o_rx_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (load_rise) begin
                  rx_state    <= RX_SHIFT;
                  rx_bit_cnt  <= '0;
                  rx_word_cnt <= '0;
               end
            end
            RX_SHIFT: begin
               if (!load_lvl) begin
                  o_rx_err <= 1'b1;
                  rx_state <= RX_IDLE;
               end else if (rx_clk_rise) begin
                  if (!word_done) begin
                     rx_shift   <= {rx_shift[SHIFT_W-2:0], rx_din};
                     rx_bit_cnt <= rx_bit_cnt + 1'b1;
                  end else if (!par_ok) begin
                     o_rx_err <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_bit_cnt <= '0;
                     if (rx_word_cnt == LAST_WORD) begin
                        o_seq_flat  <= rx_frame;
                        o_seq_valid <= 1'b1;
                        rx_state    <= RX_FULL;
                     end else begin
                        for (int k = 0; k < IN_WORDS; k++) begin
                           if (rx_word_cnt == RXW_W'(k)) begin
                              rx_buf[k*DATA_WIDTH +: DATA_WIDTH] <= word_val;
                           end
                        end
                        rx_word_cnt <= rx_word_cnt + 1'b1;
                     end
                  end
               end
            end
            RX_FULL: begin
               if (i_seq_ack) begin
                  o_seq_valid <= 1'b0;
                  rx_state    <= RX_IDLE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   logic [2:0]         tx_state;
   logic [DIV_W-1:0]   div_cnt;
   logic [TXB_W-1:0]   tx_bit_cnt;
   logic [TX_BITS-1:0] tx_sr;
   logic [TX_BITS-1:0] tx_stream;
   logic               div_done;

   // Word 0 occupies the top of the stream so a left shift sends it first, MSB first.
   always_comb begin
      tx_stream = '0;
      for (int w = 0; w < OUT_WORDS; w++) begin
         tx_stream[TX_BITS - (w+1)*WORD_BITS + PARITY_BITS +: DATA_WIDTH] =
            i_result_flat[w*DATA_WIDTH +: DATA_WIDTH];
`ifdef GRU_SERIAL_PARITY_EN
         tx_stream[TX_BITS - (w+1)*WORD_BITS] = ^i_result_flat[w*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
      div_done = (div_cnt == DIV_LAST);
   end

   // The shift happens as serial_clk_out falls, so data only moves while the clock is low.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state       <= TX_IDLE;
         div_cnt        <= '0;
         tx_bit_cnt     <= '0;
         tx_sr          <= '0;
         serial_clk_out <= 1'b0;
         serial_valid   <= 1'b0;
         o_result_ack   <= 1'b0;
      end else begin
         o_result_ack <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (i_result_valid) begin
                  tx_sr        <= tx_stream;
                  o_result_ack <= 1'b1;
                  serial_valid <= 1'b1;
                  div_cnt      <= '0;
                  tx_bit_cnt   <= '0;
                  tx_state     <= TX_SETUP;
               end
            end
            TX_SETUP, TX_LOW: begin
               if (div_done) begin
                  div_cnt        <= '0;
                  serial_clk_out <= 1'b1;
                  tx_state       <= TX_HIGH;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            TX_HIGH: begin
               if (div_done) begin
                  div_cnt        <= '0;
                  serial_clk_out <= 1'b0;
                  tx_sr          <= tx_sr << 1;
                  tx_bit_cnt     <= tx_bit_cnt + 1'b1;
                  if (tx_bit_cnt == LAST_TX) begin
                     serial_valid <= 1'b0;
                     tx_state     <= TX_END;
                  end else begin
                     tx_state <= TX_LOW;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            TX_END: begin
               if (div_done) begin
                  div_cnt  <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign serial_data_out = tx_sr[TX_BITS-1];
   assign o_tx_busy       = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_gru_serial_io.sv
// Directed bench for gru_serial_io: one single-word-TX instance and one two-word-TX instance
// sharing the RX link. Honours GRU_SERIAL_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_gru_serial_io;
   import gru_serial_pkg::*;

   localparam int PB = PARITY_BITS;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          serial_data_in = 1'b0;
   logic          serial_clk_in = 1'b0;
   logic          serial_load_en = 1'b0;
   logic          i_seq_ack = 1'b0;
   logic [31:0]   res_a = '0;
   logic          res_valid_a = 1'b0;
   logic [63:0]   res_b = '0;
   logic          res_valid_b = 1'b0;

   logic [287:0]  seq_flat_a, seq_flat_b;
   logic          seq_valid_a, seq_valid_b, rx_err_a, rx_err_b;
   logic          ack_out_a, ack_out_b, sdata_a, sdata_b, sclk_a, sclk_b;
   logic          sv_a, sv_b, busy_a, busy_b;

   int total = 0;
   int bad = 0;
   int ack_a = 0, ack_b = 0, err_a = 0;
   time tq_a[$], tq_b[$];
   logic bq_a[$], bq_b[$], svq_a[$], svq_b[$];

   typedef struct {
      logic [31:0] data;
      logic [31:0] exp_word;
      logic        exp_par;
   } tx_vec_t;
   tx_vec_t vecs [4];

   gru_serial_io #(.DATA_WIDTH(32), .IN_WORDS(9), .OUT_WORDS(1), .CLK_DIV(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstn(rstn), .serial_data_in(serial_data_in), .serial_clk_in(serial_clk_in),
      .serial_load_en(serial_load_en), .o_seq_flat(seq_flat_a), .o_seq_valid(seq_valid_a),
      .i_seq_ack(i_seq_ack), .i_result_flat(res_a), .i_result_valid(res_valid_a),
      .o_result_ack(ack_out_a), .serial_data_out(sdata_a), .serial_clk_out(sclk_a),
      .serial_valid(sv_a), .o_rx_err(rx_err_a), .o_tx_busy(busy_a)
   );

   gru_serial_io #(.DATA_WIDTH(32), .IN_WORDS(9), .OUT_WORDS(2), .CLK_DIV(2), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rstn(rstn), .serial_data_in(serial_data_in), .serial_clk_in(serial_clk_in),
      .serial_load_en(serial_load_en), .o_seq_flat(seq_flat_b), .o_seq_valid(seq_valid_b),
      .i_seq_ack(i_seq_ack), .i_result_flat(res_b), .i_result_valid(res_valid_b),
      .o_result_ack(ack_out_b), .serial_data_out(sdata_b), .serial_clk_out(sclk_b),
      .serial_valid(sv_b), .o_rx_err(rx_err_b), .o_tx_busy(busy_b)
   );

   always #5 clk = ~clk;

   // Pulse counters sample the pre-edge value of the registered outputs.
   always @(posedge clk) begin
      if (ack_out_a) ack_a++;
      if (ack_out_b) ack_b++;
      if (rx_err_a)  err_a++;
   end

   always @(posedge sclk_a) begin
      tq_a.push_back($time);
      bq_a.push_back(sdata_a);
      svq_a.push_back(sv_a);
   end

   always @(posedge sclk_b) begin
      tq_b.push_back($time);
      bq_b.push_back(sdata_b);
      svq_b.push_back(sv_b);
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic b);
      @(negedge clk); serial_data_in = b;
      repeat (2) @(negedge clk); serial_clk_in = 1'b1;
      repeat (3) @(negedge clk); serial_clk_in = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] w, input logic flip);
      for (int i = 31; i >= 0; i--) sendBit(w[i]);
      if (PB != 0) sendBit((^w) ^ flip);
   endtask

   task automatic startFrame();
      @(negedge clk); serial_load_en = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic stopFrame();
      repeat (4) @(negedge clk); serial_load_en = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic ackSeq();
      @(negedge clk); i_seq_ack = 1'b1;
      @(negedge clk); i_seq_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic waitIdleA(input string name);
      int n = 0;
      while (busy_a && n < 3000) begin @(negedge clk); n++; end
      if (busy_a) checkOutput({name, " idle timeout"}, 128'(busy_a), 128'(0));
   endtask

   // Sends one word on the single-word instance and checks ack, edge count, bits and timing.
   task automatic applyStimulus(input tx_vec_t v, input int idx);
      int n0 = tq_a.size();
      int a0 = ack_a;
      int n = 0;
      int badPer = 0, svLow = 0;
      logic [127:0] cap = '0;
      logic [127:0] exp;
      string nm = $sformatf("tx[%0d]", idx);
      @(negedge clk); res_a = v.data; res_valid_a = 1'b1;
      while (!ack_out_a && n < 20) begin @(negedge clk); n++; end
      checkOutput({nm, " sv at ack"}, 128'(sv_a), 128'(1));
      res_valid_a = 1'b0;
      waitIdleA(nm);
      repeat (4) @(negedge clk);
      checkOutput({nm, " ack count"}, 128'(ack_a - a0), 128'(1));
      checkOutput({nm, " edges"}, 128'(tq_a.size() - n0), 128'(32 + PB));
      for (int i = n0; i < tq_a.size(); i++) begin
         cap = {cap[126:0], bq_a[i]};
         if (!svq_a[i]) svLow++;
         if (i > n0 && (tq_a[i] - tq_a[i-1]) != 40) badPer++;
      end
      exp = (PB != 0) ? 128'({v.exp_word, v.exp_par}) : 128'(v.exp_word);
      checkOutput({nm, " bits"}, cap, exp);
      checkOutput({nm, " period errs"}, 128'(badPer), 128'(0));
      checkOutput({nm, " sv low at edge"}, 128'(svLow), 128'(0));
      checkOutput({nm, " sv after"}, 128'(sv_a), 128'(0));
   endtask

   initial begin
      int e0, a0, n0, n;
      logic [127:0] cap, exp;

      vecs[0] = '{data: 32'hA5A5F00F, exp_word: 32'hA5A5F00F, exp_par: 1'b0};
      vecs[1] = '{data: 32'hFFFFFFFF, exp_word: 32'hFFFFFFFF, exp_par: 1'b0};
      vecs[2] = '{data: 32'h00000001, exp_word: 32'h00000001, exp_par: 1'b1};
      vecs[3] = '{data: 32'h80000000, exp_word: 32'h80000000, exp_par: 1'b1};

      repeat (3) @(negedge clk);
      checkOutput("reset outputs",
                  128'({seq_valid_a, rx_err_a, ack_out_a, sdata_a, sclk_a, sv_a, busy_a}), 128'(0));
      checkOutput("reset flat", 128'(|seq_flat_a), 128'(0));
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] preload frame");
      startFrame();
      for (int k = 0; k < 9; k++) sendWord(32'hC0DE0000 + k, 1'b0);
      stopFrame();
      checkOutput("preload valid", 128'(seq_valid_a), 128'(1));
      checkOutput("preload slot3", 128'(seq_flat_a[3*32 +: 32]), 128'(32'hC0DE0003));
      ackSeq();

      $display("[TB] reset mid-RX with TX running");
      startFrame();
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin res_a = 32'h3C3C3C3C; res_valid_a = 1'b1; end
         sendBit(i[0]);
      end
      checkOutput("pre-reset busy", 128'(busy_a), 128'(1));
      rstn = 1'b0; serial_load_en = 1'b0; res_valid_a = 1'b0;
      #2;
      checkOutput("mid reset outputs",
                  128'({seq_valid_a, rx_err_a, ack_out_a, sdata_a, sclk_a, sv_a, busy_a}), 128'(0));
      checkOutput("mid reset flat", 128'(|seq_flat_a), 128'(0));
      repeat (3) @(negedge clk); rstn = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] full frame 1..9");
      e0 = err_a;
      startFrame();
      for (int k = 0; k < 9; k++) sendWord(32'(k + 1), 1'b0);
      @(negedge clk);
      checkOutput("frame valid", 128'(seq_valid_a), 128'(1));
      stopFrame();
      repeat (20) @(negedge clk);
      checkOutput("frame valid held", 128'(seq_valid_a), 128'(1));
      for (int k = 0; k < 9; k++)
         checkOutput($sformatf("slot%0d", k), 128'(seq_flat_a[k*32 +: 32]), 128'(k + 1));
      checkOutput("frame no err", 128'(err_a - e0), 128'(0));
      ackSeq();
      checkOutput("valid after ack", 128'(seq_valid_a), 128'(0));

      $display("[TB] abort frame");
      e0 = err_a;
      startFrame();
      for (int k = 0; k < 3; k++) sendWord(32'hAAAA0001 + k, 1'b0);
      for (int i = 0; i < 10; i++) sendBit(1'b1);
      stopFrame();
      checkOutput("abort err pulses", 128'(err_a - e0), 128'(1));
      checkOutput("abort valid", 128'(seq_valid_a), 128'(0));
      checkOutput("abort slot0 kept", 128'(seq_flat_a[0 +: 32]), 128'(1));
      checkOutput("abort slot8 kept", 128'(seq_flat_a[8*32 +: 32]), 128'(9));

      $display("[TB] TX vector table");
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

      $display("[TB] concurrent RX and two-word TX");
      n0 = tq_b.size();
      a0 = ack_b;
      fork
         begin
            startFrame();
            for (int k = 0; k < 9; k++) sendWord(32'h100 + k, 1'b0);
            stopFrame();
         end
         begin
            repeat (100) @(negedge clk);
            res_b = {32'h9ABCDEF0, 32'h12345678}; res_valid_b = 1'b1;
            n = 0;
            while (!ack_out_b && n < 20) begin @(negedge clk); n++; end
            res_valid_b = 1'b0;
            n = 0;
            while (busy_b && n < 3000) begin @(negedge clk); n++; end
            if (busy_b) checkOutput("tx2 idle timeout", 128'(busy_b), 128'(0));
         end
      join
      repeat (4) @(negedge clk);
      checkOutput("tx2 ack count", 128'(ack_b - a0), 128'(1));
      checkOutput("tx2 edges", 128'(tq_b.size() - n0), 128'(64 + 2*PB));
      cap = '0;
      for (int i = n0; i < tq_b.size(); i++) cap = {cap[126:0], bq_b[i]};
      exp = (PB != 0) ? 128'({32'h12345678, 1'b1, 32'h9ABCDEF0, 1'b1})
                      : 128'({32'h12345678, 32'h9ABCDEF0});
      checkOutput("tx2 bits", cap, exp);
      checkOutput("rx2 valid", 128'(seq_valid_b), 128'(1));
      checkOutput("rx2 slot0", 128'(seq_flat_b[0 +: 32]), 128'(32'h100));
      checkOutput("rx2 slot8", 128'(seq_flat_b[8*32 +: 32]), 128'(32'h108));
      checkOutput("rx1 slot4", 128'(seq_flat_a[4*32 +: 32]), 128'(32'h104));
      ackSeq();

      $display("[TB] held result_valid");
      n0 = tq_a.size();
      a0 = ack_a;
      @(negedge clk); res_a = 32'h0F0F1234; res_valid_a = 1'b1;
      n = 0;
      while (!busy_a && n < 20) begin @(negedge clk); n++; end
      waitIdleA("held1");
      checkOutput("held acks at idle", 128'(ack_a - a0), 128'(1));
      @(negedge clk);
      checkOutput("held restart ack", 128'(ack_out_a), 128'(1));
      res_valid_a = 1'b0;
      waitIdleA("held2");
      repeat (4) @(negedge clk);
      checkOutput("held acks total", 128'(ack_a - a0), 128'(2));
      checkOutput("held edges", 128'(tq_a.size() - n0), 128'(2*(32 + PB)));

`ifdef GRU_SERIAL_PARITY_EN
      $display("[TB] parity error frame");
      e0 = err_a;
      startFrame();
      for (int k = 0; k < 5; k++) sendWord(32'h200 + k, (k == 4) ? 1'b1 : 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("parity err pulses", 128'(err_a - e0), 128'(1));
      checkOutput("parity valid", 128'(seq_valid_a), 128'(0));
      stopFrame();
      startFrame();
      for (int k = 0; k < 9; k++) sendWord(32'h300 + k, 1'b0);
      stopFrame();
      checkOutput("parity next valid", 128'(seq_valid_a), 128'(1));
      checkOutput("parity next slot5", 128'(seq_flat_a[5*32 +: 32]), 128'(32'h305));
      checkOutput("parity err total", 128'(err_a - e0), 128'(1));
      ackSeq();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
